// File: rtl/xor_frame_accum_pkg.sv
// Shared definitions for xor_frame_accum: FSM state encoding, tile pin map
// and the parameter legality check used at elaboration time.
// Optional feature macro: PARITY_EN (frame parity on io_out[7]).
package xor_frame_accum_pkg;

  // Handshake FSM: IDLE (nothing collected, nothing held), ACCUM (frame in
  // progress, nothing held), PEND (a result is held awaiting ack).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    PEND  = 2'd2
  } state_t;

  // Tile pin map.
  localparam int CLK_I   = 0;
  localparam int RST_I   = 1;
  localparam int A_I     = 2;
  localparam int B_I     = 3;
  localparam int EN_I    = 4;
  localparam int MODE_I  = 5;
  localparam int ACK_I   = 6;
  localparam int VALID_O = 6;
  localparam int PAR_O   = 7;

  // Width of the result field on io_out.
  localparam int RES_PINS = 6;

  // Legal configuration: result fits the 6 result pins, frame length fits
  // an 8-bit count and is long enough that IDLE never completes a frame.
  function automatic bit params_ok(input int width, input int frame_len);
    return (width >= 1) && (width <= RES_PINS) &&
           (frame_len >= 2) && (frame_len <= 255);
  endfunction

endpackage

// File: rtl/xor_frame_accum_gated_shift_reg.sv
// Datapath of xor_frame_accum: gates (a ^ b) ^ mode with en, shifts accepted
// bits into a WIDTH-bit collector, counts FRAME_LEN bits per frame and keeps
// a running frame parity (only when PARITY_EN is defined).
// Next-state values are exported so the top can snapshot a frame including
// the bit accepted on the completing edge.
module gated_shift_reg
  import xor_frame_accum_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int FRAME_LEN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             en,
  input  logic             mode,
  output logic             accept,
  output logic             frame_done,
  output logic             count_nz,
  output logic [WIDTH-1:0] collector_next,
  output logic             parity_next
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] collector;
  logic             d;
  logic             frame_start;
  logic [WIDTH-1:0] base;

  // Gate, frame boundary detection and next collector value.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    d              = (a ^ b) ^ mode;
    accept         = en;
    frame_start    = (count == '0);
    frame_done     = en && (count == LAST);
    count_nz       = (count != '0);
    base           = frame_start ? '0 : collector;
    collector_next = (base << 1) | WIDTH'(d);
  end

  // Frame counter and collector; both hold while en is low and the counter
  // wraps to zero on the completing accept.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      collector <= '0;
    end else if (accept) begin
      count     <= frame_done ? '0 : count + 1'b1;
      collector <= collector_next;
    end
  end

`ifdef PARITY_EN
  logic parity;

  // Running parity, restarted on the first accept of each frame.
  always_comb begin
    parity_next = (frame_start ? 1'b0 : parity) ^ d;
  end

  // Running parity register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity <= 1'b0;
    end else if (accept) begin
      parity <= parity_next;
    end
  end
`else
  assign parity_next = 1'b0;
`endif

endmodule

// File: rtl/xor_frame_accum.sv
// xor_frame_accum: tile-level wrapper holding the handshake FSM and the
// snapshot registers in front of gated_shift_reg.
// io_out = {frame parity, valid, zero-extended held result}; all outputs come
// straight from registers. Optional feature macro: PARITY_EN.
module xor_frame_accum
  import xor_frame_accum_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int FRAME_LEN = 8
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  if (!params_ok(WIDTH, FRAME_LEN)) begin : g_param_check
    $error("xor_frame_accum: WIDTH must be 1..6 and FRAME_LEN 2..255");
  end

  logic clk;
  logic rst;
  logic ack;
  logic spare_unused;

  assign clk          = io_in[CLK_I];
  assign rst          = io_in[RST_I];
  assign ack          = io_in[ACK_I];
  assign spare_unused = io_in[7];

  logic             accept;
  logic             frame_done;
  logic             count_nz;
  logic [WIDTH-1:0] collector_next;
  logic             parity_next;

  gated_shift_reg #(
    .WIDTH     (WIDTH),
    .FRAME_LEN (FRAME_LEN)
  ) u_shift (
    .clk            (clk),
    .rst            (rst),
    .a              (io_in[A_I]),
    .b              (io_in[B_I]),
    .en             (io_in[EN_I]),
    .mode           (io_in[MODE_I]),
    .accept         (accept),
    .frame_done     (frame_done),
    .count_nz       (count_nz),
    .collector_next (collector_next),
    .parity_next    (parity_next)
  );

  state_t           state_q;
  state_t           state_d;
  logic             load;
  logic             clear;
  logic             valid;
  logic [WIDTH-1:0] result_q;
  logic             par_q;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state. A completion in PEND without ack is dropped and leaves
  // the state alone; ack in PEND returns to ACCUM only if bits remain
  // collected after this edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ACCUM;
      ACCUM:   if (frame_done) state_d = PEND;
      PEND:    if (ack && !frame_done) state_d = (count_nz || accept) ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: when to snapshot a frame and when to retire the held one.
  always_comb begin
    valid = (state_q == PEND);
    load  = frame_done && (!valid || ack);
    clear = valid && ack && !frame_done;
  end

  // Snapshot registers; the result stays visible after ack, parity does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      par_q    <= 1'b0;
    end else if (load) begin
      result_q <= collector_next;
      par_q    <= parity_next;
    end else if (clear) begin
      par_q    <= 1'b0;
    end
  end

  // Pin packing of the registered outputs.
  always_comb begin
    io_out             = 8'h00;
    io_out[RES_PINS-1:0] = RES_PINS'(result_q);
    io_out[VALID_O]    = valid;
`ifdef PARITY_EN
    io_out[PAR_O]      = par_q;
`else
    io_out[PAR_O]      = 1'b0;
`endif
  end

`ifndef PARITY_EN
  logic par_unused;
  assign par_unused = par_q ^ parity_next;
`endif

endmodule

// File: doc/xor_frame_accum.md
# xor_frame_accum

Parametrised sequential successor to the single-cycle XOR-AND gate tile. Each clock it gates the XOR (or XNOR) of two input pins with an enable, shifts the result into a WIDTH-bit collector and counts FRAME_LEN accepted bits per frame. A completed frame is snapshotted into a held result with a valid/ack handshake and optional frame parity. It sits behind the standard 8-in/8-out tile pin interface.

## Interface
- WIDTH, 6: collector/result width, 1..6, zero-extended onto io_out[5:0].
- FRAME_LEN, 8: accepted bits per frame, 2..255.
- io_in[0]  in  1  clk, rising-edge clock.
- io_in[1]  in  1  rst; one clock; reset is asynchronous and active-high.
- io_in[2]  in  1  a, data bit A.
- io_in[3]  in  1  b, data bit B.
- io_in[4]  in  1  en, accept the gated bit this cycle.
- io_in[5]  in  1  mode: 0 = XOR, 1 = XNOR.
- io_in[6]  in  1  ack, level-sampled; consumes the held result.
- io_in[7]  in  1  unused, ignored.
- io_out[5:0]  out  6  held result, WIDTH bits, upper bits 0.
- io_out[6]  out  1  valid, held result pending.
- io_out[7]  out  1  frame parity, if PARITY_EN; else 0.

## Operation
- Gated bit d = (a ^ b) ^ mode. It is accepted on a rising edge where en=1.
- Collector: shift left, d into bit 0. When count==0, d shifts into an all-zero register, so every frame starts clean.
- Counter: width $clog2(FRAME_LEN+1). Increments on each accept. The accept that makes count==FRAME_LEN completes the frame, and count returns to 0 on that edge (wrap).
- Running parity: XOR of accepted d in the current frame. It is cleared at frame start, on the same rule as the collector.
- FSM, 2-bit:
  - IDLE: count==0 and valid==0. Any accept moves to ACCUM.
  - ACCUM: count>0 and valid==0. On frame completion: snapshot collector (including the final d) into the result, snapshot parity, set valid, move to PEND.
  - PEND: valid==1. Accumulation continues into the next frame. An ack clears valid and moves to ACCUM if count>0, else to IDLE.
- Completion while in PEND without ack: the new frame is dropped, the held result is kept, and the counter and collector restart. No overflow flag.
- Completion on the same edge as ack in PEND: the new snapshot is loaded and valid stays 1.
- Ack while valid==0 is ignored.
- en=0: collector, counter, parity and FSM are held.

## Timing
- Reset, asynchronous: io_out = 8'h00; count, collector and parity are 0; FSM is IDLE.
- Reset mid-frame discards the partial frame and any held result.
- Latency: valid, result and parity update on the same edge that accepts the FRAME_LEN-th bit and are visible immediately after it.
- Ack sampled at edge N while valid clears valid after edge N.
- Throughput: one bit per cycle. A frame completes every FRAME_LEN enabled cycles.
- All outputs are registered. No combinational path from io_in to io_out.

## Configuration
- PARITY_EN defined:
  - The parity accumulator and snapshot are built.
  - io_out[7] = XOR of all FRAME_LEN bits of the held frame, valid while io_out[6]=1.
  - Cleared together with valid.
- PARITY_EN undefined:
  - No parity logic is built.
  - io_out[7] is tied to 0.

## Structure
- Package xor_frame_accum_pkg holds:
  - State enum (IDLE, ACCUM, PEND).
  - Pin index constants (CLK_I=0, RST_I=1, A_I=2, B_I=3, EN_I=4, MODE_I=5, ACK_I=6, VALID_O=6, PAR_O=7).
  - Compile-time checks on WIDTH and FRAME_LEN.
- One sub-module, gated_shift_reg:
  - Contents: gate, collector, counter and running parity.
  - Outputs: frame_done pulse, collector and parity to the top.
- The top level holds the FSM, snapshot registers and handshake.

## Test plan
All tests use WIDTH=6 and FRAME_LEN=8.
- Reset: assert rst with random inputs, then release. Required: io_out=8'h00, and no valid until 8 accepts.
- XOR frame: 8 accepts with a=1, b=0, mode=0. Required after the 8th edge: result 6'b111111, valid=1, parity 0; valid stays high with ack=0.
- Mixed XNOR frame with gaps: mode=1, d sequence 1,0,1,1,0,0,1,0 with en=0 cycles interleaved. Required: result 6'b110010, parity 0, and the en=0 cycles change nothing.
- Ack handshake: ack for one cycle. Required: valid=0 next cycle; a second ack is ignored; the next frame completes normally.
- Overrun and simultaneous events:
  - Two frames without ack: the first result is retained.
  - Third frame's final accept on the same edge as ack: the new result is loaded and valid stays 1.
- Reset mid-frame after 5 accepts. Required: outputs 0, and a full 8 fresh accepts are needed before valid rises.
